// File: rtl/ifu_fetch_if.sv
`default_nettype none
// ============================================================================
//  Module      : ifu_fetch_if
//  Description : Bundle of the fetch-stage buses. It carries the instruction
//                memory read port, the redirect port and the decode-side
//                output handshake.
//  Modports    : master - the fetch stage (drives imem_req/addr and out_*)
//                slave  - the environment (memory, branch unit, decode)
//  Parameters  : PC_W (PC width), INSTR_W (instruction width)
//  Revision    : 1.0  initial release
// ============================================================================
interface ifu_fetch_if #(
    parameter int PC_W    = 8,
    parameter int INSTR_W = 16
);
    logic               imem_req;
    logic [PC_W-1:0]    imem_addr;
    logic               imem_rvalid;
    logic [INSTR_W-1:0] imem_rdata;
    logic               redirect_valid;
    logic [PC_W-1:0]    redirect_pc;
    logic               out_valid;
    logic               out_ready;
    logic [INSTR_W-1:0] out_instr;
    logic [PC_W-1:0]    out_pc;
    logic [5:0]         out_opcode;

    modport master (
        output imem_req, imem_addr, out_valid, out_instr, out_pc, out_opcode,
        input  imem_rvalid, imem_rdata, redirect_valid, redirect_pc, out_ready
    );

    modport slave (
        input  imem_req, imem_addr, out_valid, out_instr, out_pc, out_opcode,
        output imem_rvalid, imem_rdata, redirect_valid, redirect_pc, out_ready
    );
endinterface
`default_nettype wire

// File: rtl/ifu_fetch.sv
`default_nettype none
// ============================================================================
//  Module      : ifu_fetch
//  Description : Instruction fetch stage. Owns the word-addressed PC, keeps at
//                most one instruction-memory read outstanding, buffers
//                returned words in a 2-entry queue and presents the head word
//                with its PC and 6-bit opcode to decode. A redirect flushes
//                the queue and drops any in-flight response.
//  Ports       : clk    - clock, rising edge
//                rst_n  - asynchronous active-low reset
//                bus    - ifu_fetch_if.master (imem read port, redirect port,
//                         decode output handshake)
//  Config      : IFU_HALT_EN - when defined, a kept word with opcode 6'b111111
//                stops fetching (HALTED) until a redirect or reset.
//  Revision    : 1.0  initial release
// ============================================================================
module ifu_fetch #(
    parameter int              PC_W     = 8,
    parameter int              INSTR_W  = 16,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  wire logic    clk,
    input  wire logic    rst_n,
    ifu_fetch_if.master  bus
);

`ifdef IFU_HALT_EN
    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_WAIT    = 2'd1,
        S_DISCARD = 2'd2,
        S_HALTED  = 2'd3
    } state_t;
    localparam logic [5:0] C_HALT_OPC = 6'b111111;
`else
    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_WAIT    = 2'd1,
        S_DISCARD = 2'd2
    } state_t;
`endif

    state_t             r_state;
    logic [PC_W-1:0]    r_pc;
    logic [PC_W-1:0]    r_req_addr;     // address of the outstanding read
    logic [PC_W-1:0]    r_q_pc   [0:1]; // slot 0 is always the head
    logic [INSTR_W-1:0] r_q_data [0:1];
    logic [1:0]         r_count;

    logic               w_kept;
    logic               w_pop;
    logic [1:0]         w_occ_next;
    logic               w_halt_word;
    logic               w_issue_ok;
    logic               w_req;

    // A response is only kept while waiting on a live read and not redirected.
    assign w_kept     = bus.imem_rvalid && (r_state == S_WAIT) && !bus.redirect_valid;
    assign w_pop      = (r_count != 2'd0) && bus.out_ready && !bus.redirect_valid;
    assign w_occ_next = r_count + {1'b0, w_kept} - {1'b0, w_pop};

`ifdef IFU_HALT_EN
    assign w_halt_word = w_kept && (bus.imem_rdata[INSTR_W-1 -: 6] == C_HALT_OPC);
`else
    assign w_halt_word = 1'b0;
`endif

    // A new read may overlap the cycle in which the previous one returns.
    assign w_issue_ok = (r_state == S_IDLE) || ((r_state == S_WAIT) && bus.imem_rvalid);

    // Issue only if the word can be guaranteed a queue slot when it returns;
    // rst_n gates the request so nothing is issued while reset is held.
    assign w_req = rst_n && w_issue_ok && !bus.redirect_valid
                 && (w_occ_next <= 2'd1) && !w_halt_word;

    assign bus.imem_req   = w_req;
    assign bus.imem_addr  = r_pc;
    assign bus.out_valid  = (r_count != 2'd0);
    assign bus.out_instr  = r_q_data[0];
    assign bus.out_pc     = r_q_pc[0];
    assign bus.out_opcode = r_q_data[0][INSTR_W-1 -: 6];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_pc        <= RESET_PC;
            r_req_addr  <= '0;
            r_q_pc[0]   <= '0;
            r_q_pc[1]   <= '0;
            r_q_data[0] <= '0;
            r_q_data[1] <= '0;
            r_count     <= 2'd0;
        end else if (bus.redirect_valid) begin
            r_pc    <= bus.redirect_pc;
            r_count <= 2'd0;
            // A read still in flight must be swallowed when it returns.
            if (((r_state == S_WAIT) || (r_state == S_DISCARD)) && !bus.imem_rvalid)
                r_state <= S_DISCARD;
            else
                r_state <= S_IDLE;
        end else begin
            if (w_req) begin
                r_pc       <= r_pc + PC_W'(1);
                r_req_addr <= r_pc;
            end

            case ({w_kept, w_pop})
                2'b10: begin
                    r_q_pc[r_count[0]]   <= r_req_addr;
                    r_q_data[r_count[0]] <= bus.imem_rdata;
                    r_count              <= r_count + 2'd1;
                end
                2'b01: begin
                    r_q_pc[0]   <= r_q_pc[1];
                    r_q_data[0] <= r_q_data[1];
                    r_count     <= r_count - 2'd1;
                end
                2'b11: begin
                    if (r_count == 2'd1) begin
                        r_q_pc[0]   <= r_req_addr;
                        r_q_data[0] <= bus.imem_rdata;
                    end else begin
                        r_q_pc[0]   <= r_q_pc[1];
                        r_q_data[0] <= r_q_data[1];
                        r_q_pc[1]   <= r_req_addr;
                        r_q_data[1] <= bus.imem_rdata;
                    end
                end
                default: ;
            endcase

            case (r_state)
                S_IDLE: begin
                    if (w_req) r_state <= S_WAIT;
                end
                S_WAIT: begin
                    if (bus.imem_rvalid) begin
`ifdef IFU_HALT_EN
                        if (w_halt_word)
                            r_state <= S_HALTED;
                        else
`endif
                        r_state <= w_req ? S_WAIT : S_IDLE;
                    end
                end
                S_DISCARD: begin
                    if (bus.imem_rvalid) r_state <= S_IDLE;
                end
`ifdef IFU_HALT_EN
                S_HALTED: r_state <= S_HALTED;
`endif
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire
